// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter and broadcast register for the common data bus of the
// Tomasulo core. Functional units (four ALU reservation stations plus the
// load/store unit) raise a request when they hold a completed result. At most
// one of them is granted per cycle. The granted tag/data are captured and
// broadcast to all CDB consumers during the following cycle.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   i_req        in   [NUM_REQ]        bit i: requester i holds a valid result
//   i_req_tag    in   [NUM_REQ*TAG_W]  requester i tag at [i*TAG_W +: TAG_W]
//   i_req_data   in   [NUM_REQ*DATA_W] requester i data at [i*DATA_W +: DATA_W]
//   i_flush      in   branch mispredict, suppresses arbitration this cycle
//   o_grant      out  [NUM_REQ]  one-hot or zero grant, same cycle as request
//   o_cdb_valid  out  registered broadcast valid
//   o_cdb_tag    out  [TAG_W]    registered broadcast ROB tag
//   o_cdb_data   out  [DATA_W]   registered broadcast data
// ----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int NUM_REQ = 5,
   parameter int TAG_W   = 3,
   parameter int DATA_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [NUM_REQ*TAG_W-1:0]   i_req_tag,
   input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
   input  logic                       i_flush,
   output logic [NUM_REQ-1:0]         o_grant,
   output logic                       o_cdb_valid,
   output logic [TAG_W-1:0]           o_cdb_tag,
   output logic [DATA_W-1:0]          o_cdb_data
);

   // Pointer width; kept at least one bit so a degenerate single-requester
   // configuration still elaborates.
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
   localparam logic [PTR_W:0]   SUM_WRAP = (PTR_W + 1)'(NUM_REQ);

   // Registered state
   logic [PTR_W-1:0]  r_ptr;
   logic              r_cdb_valid;
   logic [TAG_W-1:0]  r_cdb_tag;
   logic [DATA_W-1:0] r_cdb_data;

   // Combinational arbitration results
   logic              w_found;
   logic [PTR_W-1:0]  w_win;
   logic              w_grant_en;
   logic [NUM_REQ-1:0] w_grant;
   logic [TAG_W-1:0]  w_win_tag;
   logic [DATA_W-1:0] w_win_data;
   logic [PTR_W-1:0]  w_ptr_next;

   // Round-robin scan: first requester at or after the pointer, wrapping.
   always_comb begin
      logic [PTR_W:0]   v_sum;
      logic [PTR_W-1:0] v_idx;
      w_found = 1'b0;
      w_win   = '0;
      v_sum   = '0;
      v_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // ptr + k, folded back into 0..NUM_REQ-1 with one conditional subtract
         // since both operands are already below NUM_REQ.
         v_sum = {1'b0, r_ptr} + (PTR_W + 1)'(k);
         if (v_sum >= SUM_WRAP) begin
            v_sum = v_sum - SUM_WRAP;
         end else begin
            v_sum = v_sum;
         end
         v_idx = v_sum[PTR_W-1:0];
         if (!w_found && i_req[v_idx]) begin
            w_found = 1'b1;
            w_win   = v_idx;
         end else begin
            w_found = w_found;
         end
      end
   end

   // Grant qualification: reset and flush both kill the grant outright.
   always_comb begin
      w_grant_en = w_found && !i_flush && !rst;
      w_grant    = '0;
      if (w_grant_en) begin
         w_grant[w_win] = 1'b1;
      end else begin
         w_grant = '0;
      end
   end

   // Winner payload select, written as a mux over constant slices.
   always_comb begin
      w_win_tag  = '0;
      w_win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == PTR_W'(i)) begin
            w_win_tag  = i_req_tag[i*TAG_W +: TAG_W];
            w_win_data = i_req_data[i*DATA_W +: DATA_W];
         end else begin
            w_win_tag  = w_win_tag;
            w_win_data = w_win_data;
         end
      end
   end

   // Next pointer: one past the winner on a grant, otherwise unchanged.
   always_comb begin
      w_ptr_next = r_ptr;
      if (w_grant_en) begin
         if (w_win == PTR_LAST) begin
            w_ptr_next = '0;
         end else begin
            w_ptr_next = w_win + PTR_W'(1);
         end
      end else begin
         w_ptr_next = r_ptr;
      end
   end

   // Pointer and broadcast register update.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_cdb_valid <= 1'b0;
         r_cdb_tag   <= '0;
         r_cdb_data  <= '0;
      end else begin
         r_ptr       <= w_ptr_next;
         r_cdb_valid <= w_grant_en;
         // Tag/data hold when idle; consumers only look at them with valid.
         if (w_grant_en) begin
            r_cdb_tag  <= w_win_tag;
            r_cdb_data <= w_win_data;
         end else begin
            r_cdb_tag  <= r_cdb_tag;
            r_cdb_data <= r_cdb_data;
         end
      end
   end

   assign o_grant     = w_grant;
   assign o_cdb_valid = r_cdb_valid;
   assign o_cdb_tag   = r_cdb_tag;
   assign o_cdb_data  = r_cdb_data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter. Inputs change 1 ns after each rising edge;
// grant and the broadcast register are sampled 2 ns after the edge, so in each
// cycle window the bench sees this cycle's grant and the broadcast of the
// previous cycle's winner.
// ----------------------------------------------------------------------------
module tb_cdb_arbiter;

   localparam int NUM_REQ = 5;
   localparam int TAG_W   = 3;
   localparam int DATA_W  = 32;

   logic                      clk;
   logic                      rst;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*TAG_W-1:0]  req_tag;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      flush;
   logic [NUM_REQ-1:0]        grant;
   logic                      cdb_valid;
   logic [TAG_W-1:0]          cdb_tag;
   logic [DATA_W-1:0]         cdb_data;

   logic [TAG_W-1:0]  tags  [NUM_REQ];
   logic [DATA_W-1:0] datas [NUM_REQ];

   int n_checks = 0;
   int n_errors = 0;

   cdb_arbiter #(
      .NUM_REQ (NUM_REQ),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_req       (req),
      .i_req_tag   (req_tag),
      .i_req_data  (req_data),
      .i_flush     (flush),
      .o_grant     (grant),
      .o_cdb_valid (cdb_valid),
      .o_cdb_tag   (cdb_tag),
      .o_cdb_data  (cdb_data)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack per-requester tag/data tables onto the flat buses.
   always_comb begin
      req_tag  = '0;
      req_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_tag[i*TAG_W +: TAG_W]    = tags[i];
         req_data[i*DATA_W +: DATA_W] = datas[i];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle window (1 ns after the rising edge).
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Expected round-robin sequence with all five requesting from ptr=0.
   logic [4:0] rr_grant [6];
   logic [2:0] rr_tag   [6];
   logic       rr_valid [6];

   initial begin
      rr_grant = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      rr_valid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      rr_tag   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

      rst   = 1'b1;
      flush = 1'b0;
      req   = 5'b11111;
      for (int i = 0; i < NUM_REQ; i++) begin
         tags[i]  = 3'(i + 1);
         datas[i] = 32'h0000_00A0 + 32'(i);
      end

      // ---------------- reset held 5 cycles with all requests up -----------
      next_cycle();
      for (int c = 0; c < 5; c++) begin
         #1;
         check_val("rst_grant", 32'(grant), 32'h0);
         check_val("rst_valid", 32'(cdb_valid), 32'h0);
         check_val("rst_tag",   32'(cdb_tag), 32'h0);
         check_val("rst_data",  cdb_data, 32'h0);
         next_cycle();
      end

      // ---------------- round-robin wrap from ptr=0 -------------------------
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         check_val("rr_grant", 32'(grant), 32'(rr_grant[c]));
         check_val("rr_valid", 32'(cdb_valid), 32'(rr_valid[c]));
         if (rr_valid[c]) begin
            check_val("rr_tag", 32'(cdb_tag), 32'(rr_tag[c]));
         end
         next_cycle();
      end
      req = 5'b00000;
      #1;
      check_val("rr_last_valid", 32'(cdb_valid), 32'h1);
      check_val("rr_last_tag",   32'(cdb_tag), 32'h1);
      check_val("rr_last_data",  cdb_data, 32'h0000_00A0);
      check_val("idle_grant",    32'(grant), 32'h0);
      next_cycle();

      // ---------------- single requester (ptr=1) ----------------------------
      req      = 5'b00100;
      tags[2]  = 3'd5;
      datas[2] = 32'h0000_000B;
      #1;
      check_val("single_grant",     32'(grant), 32'h04);
      check_val("single_pre_valid", 32'(cdb_valid), 32'h0);
      next_cycle();
      req = 5'b00000;
      #1;
      check_val("single_valid", 32'(cdb_valid), 32'h1);
      check_val("single_tag",   32'(cdb_tag), 32'h5);
      check_val("single_data",  cdb_data, 32'h0000_000B);
      check_val("single_idle",  32'(grant), 32'h0);
      next_cycle();
      #1;
      check_val("single_drop_valid", 32'(cdb_valid), 32'h0);

      // ---------------- pointer skip (ptr=3, req=00011) ---------------------
      req = 5'b00011;
      #1;
      check_val("skip_grant0", 32'(grant), 32'h01);
      next_cycle();
      #1;
      check_val("skip_grant1", 32'(grant), 32'h02);
      check_val("skip_tag0",   32'(cdb_tag), 32'h1);
      next_cycle();
      // ptr should now be 2: with req=00110 it picks 2 (ptr 1 or 3 would pick 1)
      req = 5'b00110;
      #1;
      check_val("skip_ptr2",  32'(grant), 32'h04);
      check_val("skip_tag1",  32'(cdb_tag), 32'h2);
      check_val("skip_valid", 32'(cdb_valid), 32'h1);
      next_cycle();

      // ---------------- flush (ptr=3) ---------------------------------------
      req     = 5'b10001;
      tags[4] = 3'd7;
      flush   = 1'b1;
      #1;
      check_val("flush_grant",     32'(grant), 32'h0);
      check_val("flush_inflight",  32'(cdb_valid), 32'h1);
      check_val("flush_inflt_tag", 32'(cdb_tag), 32'h5);
      next_cycle();
      flush = 1'b0;
      #1;
      check_val("flush_valid", 32'(cdb_valid), 32'h0);
      check_val("flush_after", 32'(grant), 32'h10);
      next_cycle();
      req = 5'b00001;
      #1;
      check_val("flush_bc_valid", 32'(cdb_valid), 32'h1);
      check_val("flush_bc_tag",   32'(cdb_tag), 32'h7);
      check_val("flush_wrap",     32'(grant), 32'h01);
      next_cycle();
      req = 5'b00000;
      #1;
      check_val("flush_r0_tag", 32'(cdb_tag), 32'h1);
      next_cycle();

      // ---------------- back-to-back from requester 0 (ptr=1) --------------
      for (int c = 0; c < 3; c++) begin
         req     = 5'b00001;
         tags[0] = 3'(c + 1);
         #1;
         check_val("b2b_grant", 32'(grant), 32'h01);
         if (c > 0) begin
            check_val("b2b_valid", 32'(cdb_valid), 32'h1);
            check_val("b2b_tag",   32'(cdb_tag), 32'(c));
         end
         next_cycle();
      end
      req = 5'b00000;
      #1;
      check_val("b2b_last_valid", 32'(cdb_valid), 32'h1);
      check_val("b2b_last_tag",   32'(cdb_tag), 32'h3);
      next_cycle();
      #1;
      check_val("b2b_end_valid", 32'(cdb_valid), 32'h0);

      // ---------------- reset mid-stream ------------------------------------
      req = 5'b11111;
      rst = 1'b1;
      #1;
      check_val("mrst_grant", 32'(grant), 32'h0);
      next_cycle();
      rst = 1'b0;
      #1;
      check_val("mrst_valid", 32'(cdb_valid), 32'h0);
      check_val("mrst_tag",   32'(cdb_tag), 32'h0);
      check_val("mrst_ptr0",  32'(grant), 32'h01);
      next_cycle();
      req = 5'b00000;
      #1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
